// File: rtl/spi_amba_bridge.sv
// spi_amba_bridge: AMBA-style slave bus to SPI master bridge with TX/RX FIFOs.
// Define SPI_AMBA_BRIDGE_IRQ_EN to enable the CTRL register and level interrupt.

module spi_amba_bridge_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign rdata = mem[rp];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
endmodule

module spi_amba_bridge #(
   parameter  int DATA_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hsel,
   input  logic              hwrite,
   input  logic [31:0]       haddr,
   input  logic [31:0]       hwdata,
   output logic [31:0]       hrdata,
   input  logic [DATA_W-1:0] spi_data_out,
   input  logic              spi_busy,
   output logic [DATA_W-1:0] spi_data_in,
   output logic              spi_ready_send,
   output logic              irq
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t state;

   logic [3:0] off;
   logic       bus_wr;
   logic       bus_rd;
   logic       wr_tx;
   logic       wr_stat;
   logic       wr_ctrl;
   logic       rd_rx;

   logic              tx_push;
   logic              tx_pop;
   logic [DATA_W-1:0] tx_head;
   logic [CNT_W-1:0]  tx_count;
   logic              tx_full;
   logic              tx_empty;

   logic              rx_push_req;
   logic              rx_push;
   logic              rx_pop;
   logic [DATA_W-1:0] rx_head;
   logic [CNT_W-1:0]  rx_count;
   logic              rx_full;
   logic              rx_empty;

   logic        tx_ovf;
   logic        rx_ovf;
   logic        busy;
   logic [31:0] status;
   logic [31:0] ctrl_rd;
   logic [31:0] rd_mux;
   logic        unused_ok;

   assign off     = haddr[3:0];
   assign bus_wr  = hsel & hwrite;
   assign bus_rd  = hsel & ~hwrite;
   assign wr_tx   = bus_wr & (off == 4'h0);
   assign wr_stat = bus_wr & (off == 4'h8);
   assign wr_ctrl = bus_wr & (off == 4'hC);
   assign rd_rx   = bus_rd & (off == 4'h4);

   // A full TX FIFO still accepts a write when the FSM pops it this cycle
   assign tx_pop  = (state == S_LAUNCH);
   assign tx_push = wr_tx & (~tx_full | tx_pop);

   assign rx_push_req = (state == S_WAIT_DONE) & ~spi_busy;
   assign rx_pop      = rd_rx & ~rx_empty;
   assign rx_push     = rx_push_req & (~rx_full | rx_pop);

   spi_amba_bridge_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH),
      .CW    (CNT_W)
   ) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (hwdata[DATA_W-1:0]),
      .rdata (tx_head),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   spi_amba_bridge_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH),
      .CW    (CNT_W)
   ) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (spi_data_out),
      .rdata (rx_head),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_ovf <= 1'b0;
         rx_ovf <= 1'b0;
      end else begin
         if (wr_tx & tx_full & ~tx_pop)
            tx_ovf <= 1'b1;
         else if (wr_stat & hwdata[5])
            tx_ovf <= 1'b0;
         if (rx_push_req & rx_full & ~rx_pop)
            rx_ovf <= 1'b1;
         else if (wr_stat & hwdata[6])
            rx_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         spi_ready_send <= 1'b0;
         spi_data_in    <= '0;
      end else begin
         spi_ready_send <= 1'b0;
         case (state)
            S_IDLE: begin
               if (~tx_empty & ~spi_busy) begin
                  state          <= S_LAUNCH;
                  spi_ready_send <= 1'b1;
                  spi_data_in    <= tx_head;
               end
            end
            S_LAUNCH:    state <= S_WAIT_BUSY;
            S_WAIT_BUSY: if (spi_busy) state <= S_WAIT_DONE;
            S_WAIT_DONE: if (~spi_busy) state <= S_IDLE;
            default:     state <= S_IDLE;
         endcase
      end
   end

   assign busy   = (state != S_IDLE) | spi_busy;
   assign status = {8'h00, 8'(rx_count), 8'(tx_count), 1'b0,
                    rx_ovf, tx_ovf, busy, rx_empty, rx_full,
                    tx_empty, tx_full};

`ifdef SPI_AMBA_BRIDGE_IRQ_EN
   logic [2:0] ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl <= '0;
         irq  <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl <= hwdata[2:0];
         irq <= (ctrl[0] & ~rx_empty)
              | (ctrl[1] & tx_empty & (state == S_IDLE))
              | (ctrl[2] & (tx_ovf | rx_ovf));
      end
   end

   assign ctrl_rd = {29'd0, ctrl};
`else
   assign ctrl_rd = '0;
   assign irq     = 1'b0;
`endif

   always_comb begin
      rd_mux = '0;
      case (off)
         4'h4:    rd_mux = rx_empty ? '0 : 32'(rx_head);
         4'h8:    rd_mux = status;
         4'hC:    rd_mux = ctrl_rd;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hrdata <= '0;
      else if (bus_rd)
         hrdata <= rd_mux;
   end

   assign unused_ok = ^{hwdata, haddr[31:4], wr_ctrl};
endmodule

// File: tb/tb_spi_amba_bridge.sv
// Directed self-checking bench for spi_amba_bridge (DATA_W=8, FIFO_DEPTH=4).
// Covers reset, single transfer, TX/RX overflow, W1C, irq and mid-transfer reset.

module tb_spi_amba_bridge;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic [7:0]  spi_data_out;
   logic        spi_busy;
   logic [7:0]  spi_data_in;
   logic        spi_ready_send;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   spi_amba_bridge #(
      .DATA_W     (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .hsel           (hsel),
      .hwrite         (hwrite),
      .haddr          (haddr),
      .hwdata         (hwdata),
      .hrdata         (hrdata),
      .spi_data_out   (spi_data_out),
      .spi_busy       (spi_busy),
      .spi_data_in    (spi_data_in),
      .spi_ready_send (spi_ready_send),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      hsel   = 1'b1;
      hwrite = 1'b1;
      haddr  = a;
      hwdata = d;
      tick();
      hsel   = 1'b0;
      hwrite = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      hsel   = 1'b1;
      hwrite = 1'b0;
      haddr  = a;
      tick();
      hsel   = 1'b0;
      d      = hrdata;
   endtask

   task automatic do_core(input logic [7:0] reply, output logic [7:0] sent);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (spi_ready_send) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check("launch_seen", 32'(seen), 32'd1);
      sent     = spi_data_in;
      spi_busy = 1'b1;
      tick();
      tick();
      tick();
      spi_data_out = reply;
      spi_busy     = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [7:0]  sent;

      rst_n        = 1'b1;
      hsel         = 1'b0;
      hwrite       = 1'b0;
      haddr        = '0;
      hwdata       = '0;
      spi_data_out = '0;
      spi_busy     = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_hrdata", hrdata, 32'h0);
      check("rst_sds", 32'(spi_data_in), 32'h0);
      check("rst_send", 32'(spi_ready_send), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      bus_read(32'h8, rd);
      check("rst_status", rd, 32'h0000_000A);
      check("rst_send2", 32'(spi_ready_send), 32'h0);
      bus_read(32'h2, rd);
      check("bad_off_rd", rd, 32'h0);

      // single transfer with echo of ~data
      bus_write(32'h0, 32'hA5);
      check("t1_nopulse", 32'(spi_ready_send), 32'h0);
      tick();
      check("t1_pulse", 32'(spi_ready_send), 32'h1);
      check("t1_data", 32'(spi_data_in), 32'hA5);
      tick();
      check("t1_pulse_end", 32'(spi_ready_send), 32'h0);
      spi_busy = 1'b1;
      tick();
      bus_read(32'h8, rd);
      check("t1_st_busy", rd, 32'h0000_001A);
      repeat (8) tick();
      spi_data_out = 8'h5A;
      spi_busy     = 1'b0;
      tick();
      bus_read(32'h8, rd);
      check("t1_st_rx1", rd, 32'h0001_0002);
      bus_read(32'h4, rd);
      check("t1_rxdata", rd, 32'h0000_005A);
      bus_read(32'h8, rd);
      check("t1_st_rx0", rd, 32'h0000_000A);

      // TX overflow while the core stays busy
      bus_write(32'h0, 32'h01);
      tick();
      check("t2_pulse", 32'(spi_ready_send), 32'h1);
      check("t2_data", 32'(spi_data_in), 32'h01);
      spi_busy = 1'b1;
      bus_write(32'h0, 32'h02);
      bus_write(32'h0, 32'h03);
      bus_write(32'h0, 32'h04);
      bus_write(32'h0, 32'h05);
      bus_write(32'h0, 32'h06);
      bus_read(32'h8, rd);
      check("t2_st_ovf", rd, 32'h0000_0439);
      bus_write(32'h8, 32'h20);
      bus_read(32'h8, rd);
      check("t2_st_w1c", rd, 32'h0000_0419);

      // full TX push accepted in the LAUNCH pop cycle
      spi_data_out = 8'hB1;
      spi_busy     = 1'b0;
      tick();
      tick();
      check("t3_pulse", 32'(spi_ready_send), 32'h1);
      check("t3_data", 32'(spi_data_in), 32'h02);
      spi_busy = 1'b1;
      bus_write(32'h0, 32'h07);
      bus_read(32'h8, rd);
      check("t3_st_pushpop", rd, 32'h0001_0411);
      spi_data_out = 8'hB2;
      spi_busy     = 1'b0;
      tick();

      // fill RX, then overflow it
      do_core(8'hB3, sent);
      check("t4_sent3", 32'(sent), 32'h03);
      do_core(8'hB4, sent);
      check("t4_sent4", 32'(sent), 32'h04);
      do_core(8'hB5, sent);
      check("t4_sent5", 32'(sent), 32'h05);
      do_core(8'hB7, sent);
      check("t4_sent7", 32'(sent), 32'h07);
      bus_read(32'h8, rd);
      check("t4_st_rxovf", rd, 32'h0004_0046);
      bus_read(32'h4, rd);
      check("t4_rx1", rd, 32'hB1);
      bus_read(32'h4, rd);
      check("t4_rx2", rd, 32'hB2);
      bus_read(32'h4, rd);
      check("t4_rx3", rd, 32'hB3);
      bus_read(32'h4, rd);
      check("t4_rx4", rd, 32'hB4);
      bus_read(32'h4, rd);
      check("t4_rx_empty", rd, 32'h0);
      bus_read(32'h8, rd);
      check("t4_st_empty", rd, 32'h0000_004A);
      bus_write(32'h8, 32'h40);
      bus_read(32'h8, rd);
      check("t4_st_clr", rd, 32'h0000_000A);

`ifdef SPI_AMBA_BRIDGE_IRQ_EN
      bus_write(32'hC, 32'h1);
      bus_read(32'hC, rd);
      check("t5_ctrl", rd, 32'h1);
      check("t5_irq_idle", 32'(irq), 32'h0);
      bus_write(32'h0, 32'h3C);
      do_core(8'hC3, sent);
      check("t5_sent", 32'(sent), 32'h3C);
      check("t5_irq_lag", 32'(irq), 32'h0);
      tick();
      check("t5_irq_rise", 32'(irq), 32'h1);
      bus_read(32'h4, rd);
      check("t5_rx", rd, 32'hC3);
      check("t5_irq_hold", 32'(irq), 32'h1);
      tick();
      check("t5_irq_fall", 32'(irq), 32'h0);
      bus_write(32'hC, 32'h0);
`else
      bus_write(32'hC, 32'h7);
      bus_read(32'hC, rd);
      check("t5_ctrl_off", rd, 32'h0);
      bus_write(32'h0, 32'h3C);
      do_core(8'hC3, sent);
      check("t5_sent", 32'(sent), 32'h3C);
      tick();
      check("t5_irq_off", 32'(irq), 32'h0);
      bus_read(32'h4, rd);
      check("t5_rx", rd, 32'hC3);
`endif

      // reset while waiting for the core to finish
      bus_write(32'h0, 32'h99);
      tick();
      check("t6_pulse", 32'(spi_ready_send), 32'h1);
      spi_busy = 1'b1;
      tick();
      tick();
      bus_read(32'h8, rd);
      check("t6_st_busy", rd, 32'h0000_001A);
      spi_data_out = 8'h66;
      #2 rst_n = 1'b0;
      spi_busy = 1'b0;
      #1;
      check("t6_hrdata", hrdata, 32'h0);
      check("t6_sds", 32'(spi_data_in), 32'h0);
      check("t6_send", 32'(spi_ready_send), 32'h0);
      check("t6_irq", 32'(irq), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      bus_read(32'h8, rd);
      check("t6_status", rd, 32'h0000_000A);
      check("t6_send2", 32'(spi_ready_send), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_amba_bridge.md
# spi_amba_bridge

Parametrised bus-to-SPI bridge between the AMBA-style slave bus and the SPI master core. Buffers outgoing words in a TX FIFO and received words in an RX FIFO, so the bus master can queue transfers without polling busy per word. Runs a launch/track FSM that hands one word at a time to the SPI core and captures its reply. Exposes sticky overflow status and an optional interrupt.

## Interface
- DATA_W, 8: SPI word width in bits, 1..32.
- FIFO_DEPTH, 4: entries per FIFO; power of two, 2..128.
- CNT_W, $clog2(FIFO_DEPTH)+1: occupancy counter width (derived, not overridden).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hsel  in  1  bridge selected this cycle.
- hwrite  in  1  1 = write, 0 = read.
- haddr  in  32  byte address; only [3:0] decoded.
- hwdata  in  32  write data.
- hrdata  out  32  registered read data.
- spi_data_out  in  DATA_W  word received by the SPI core.
- spi_busy  in  1  SPI core transfer in progress.
- spi_data_in  out  DATA_W  word to transmit.
- spi_ready_send  out  1  one-cycle start pulse to the SPI core.
- irq  out  1  level interrupt.

## Operation
- Register map (haddr[3:0]); other offsets ignore writes and read 0.
  - 0x0 TXDATA (W): push hwdata[DATA_W-1:0] into the TX FIFO.
  - 0x4 RXDATA (R): return the RX head zero-extended, then pop.
  - 0x8 STATUS (R; W1C on [6:5]): [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] busy (FSM not IDLE or spi_busy), [5] tx_ovf, [6] rx_ovf, [15:8] tx_count, [23:16] rx_count.
  - 0xC CTRL (R/W): [0] ie_rx_nonempty, [1] ie_tx_empty, [2] ie_ovf.
- Write to TXDATA when TX FIFO is full: data is dropped and tx_ovf is set.
  - Exception: if the FSM pops in the same cycle, the push is accepted.
- Read of RXDATA when RX FIFO is empty: returns 0, no pop, no flag.
- FSM states:
  - IDLE -> LAUNCH when the TX FIFO is not empty and spi_busy=0.
  - LAUNCH (one cycle): drive spi_data_in = TX head, assert spi_ready_send, pop TX. -> WAIT_BUSY.
  - WAIT_BUSY: stay until spi_busy=1. -> WAIT_DONE.
  - WAIT_DONE: on spi_busy=0, push spi_data_out into the RX FIFO. -> IDLE.
- RX push while the RX FIFO is full: word dropped, rx_ovf set; push-and-pop in the same cycle is allowed.
- spi_data_in holds its last launched value between transfers.
- Both FIFOs are circular with wrap-around pointers; count = pushes - pops, never exceeding FIFO_DEPTH.

## Timing
- Reset values (asynchronous on rst_n low): hrdata=0, spi_data_in=0, spi_ready_send=0, irq=0.
  - FSM=IDLE, FIFOs empty, flags 0, CTRL 0.
- Reset mid-transfer: state is discarded. Words queued or in flight are lost.
- Read latency: hrdata is valid at the rising edge after the hsel && !hwrite cycle, and holds until the next read.
- Writes take effect at the same edge that samples them.
- TX write to spi_ready_send (FIFO empty, core idle): cycle N write, N+1 IDLE->LAUNCH, pulse visible during N+2.
- Back-to-back transfers: next LAUNCH at earliest 2 cycles after spi_busy falls.
- STATUS reflects state registered at the sampling edge.

## Configuration
- SPI_AMBA_BRIDGE_IRQ_EN defined:
  - irq = (ie_rx_nonempty & !rx_empty) | (ie_tx_empty & tx_empty & FSM IDLE) | (ie_ovf & (tx_ovf | rx_ovf)).
  - irq is registered, so it lags the cause by one cycle.
- SPI_AMBA_BRIDGE_IRQ_EN undefined:
  - irq is tied 0.
  - CTRL writes are ignored and CTRL reads 0.

## Test plan
- Reset then read STATUS -> hrdata=0x0000_000A (tx_empty, rx_empty), spi_ready_send=0.
- Write 0xA5 to TXDATA with a model core that echoes ~data after 10 busy cycles -> spi_ready_send pulses once with spi_data_in=0xA5; RXDATA read returns 0x5A; STATUS rx_count 1->0.
- FIFO_DEPTH=4, core held busy, 6 TXDATA writes:
  - expect 1 launched plus 4 queued; the 6th is dropped and tx_ovf=1;
  - write 0x20 to STATUS -> tx_ovf=0.
- Four RX words with no reads, then a fifth transfer -> rx_full=1, rx_ovf=1, and reads return the first four words in order.
- IRQ_EN build, CTRL=0x1, one transfer -> irq rises 1 cycle after the RX push and falls 1 cycle after the RXDATA read empties the FIFO.
- rst_n low during WAIT_DONE -> all outputs 0 immediately; after release, STATUS=0x0000_000A and no RX push occurs.
